// File: rtl/execute_muldiv.sv
// execute_muldiv: iterative multiply/divide unit for the execute stage.
// It owns the HI/LO registers. MULT/MULTU use shift-add and DIV/DIVU use
// restoring division, each resolving one bit per cycle. A single FIXUP cycle
// then applies the result signs and writes HI/LO.
// Optional build macro: MULDIV_EARLY_OUT_EN. When it is defined, MUL stops
// once the remaining multiplier bits are all zero.
module execute_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_e,
  input  logic             sig_clr,
  input  logic [2:0]       op_e,
  input  logic [WIDTH-1:0] src_a_e,
  input  logic [WIDTH-1:0] src_b_e,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIXUP} state_t;

  state_t state, state_nxt;

  logic [CNT_W-1:0]   count;
  logic [WIDTH-1:0]   hi_r, lo_r;

  // Datapath state. It has no reset because every field is loaded when an
  // operation is accepted.
  logic [2*WIDTH-1:0] prod;    // MUL: running product; DIV: {remainder, quotient}
  logic [2*WIDTH-1:0] mcand;   // MUL: multiplicand magnitude, shifted left each step
  logic [WIDTH-1:0]   mplier;  // MUL: remaining multiplier bits; DIV: divisor magnitude
  logic               is_div;
  logic               neg_res; // sign(a)^sign(b) for signed ops
  logic               neg_rem; // sign(a) for DIV
  logic               div_zero;

  // Conditional two's-complement negation, single width.
  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  // Conditional two's-complement negation, double width (product fixup).
  function automatic logic [2*WIDTH-1:0] cond_neg2(input logic [2*WIDTH-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  logic accept, op_mul, op_div, op_signed, sgn_a, sgn_b, last_iter, mul_done;
  logic [2*WIDTH-1:0] mul_sum;
  logic [WIDTH:0]     div_shift, div_diff;
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]   fix_hi, fix_lo;

  assign accept    = start_e && !sig_clr && (state == IDLE);
  assign op_mul    = (op_e == 3'd0) || (op_e == 3'd1);
  assign op_div    = (op_e == 3'd2) || (op_e == 3'd3);
  assign op_signed = (op_e == 3'd0) || (op_e == 3'd2);
  assign sgn_a     = op_signed && ($signed(src_a_e) < 0);
  assign sgn_b     = op_signed && ($signed(src_b_e) < 0);
  assign last_iter = (count == CNT_W'(WIDTH - 1));

`ifdef MULDIV_EARLY_OUT_EN
  assign mul_done  = last_iter || (mplier[WIDTH-1:1] == '0);
`else
  assign mul_done  = last_iter;
`endif

  // One step of shift-add and one step of restoring division.
  always_comb begin
    mul_sum   = prod + (mplier[0] ? mcand : '0);
    div_shift = {prod[2*WIDTH-1:WIDTH], prod[WIDTH-1]};
    div_diff  = div_shift - {1'b0, mplier};
  end

  // Sign fixup of the final result. A divide by zero leaves LO all ones.
  // HI is the dividend magnitude re-signed, which reproduces the raw dividend.
  always_comb begin
    prod_s = cond_neg2(prod, neg_res);
    fix_hi = prod_s[2*WIDTH-1:WIDTH];
    fix_lo = prod_s[WIDTH-1:0];
    if (is_div) begin
      fix_hi = cond_neg(prod[2*WIDTH-1:WIDTH], neg_rem);
      fix_lo = div_zero ? '1 : cond_neg(prod[WIDTH-1:0], neg_res);
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept && op_mul) state_nxt = MUL;
        else if (accept && op_div) state_nxt = DIV;
      end
      MUL:     if (mul_done)  state_nxt = FIXUP;
      DIV:     if (last_iter) state_nxt = FIXUP;
      FIXUP:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Control registers: state, iteration counter and the architectural HI/LO.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      count <= '0;
      hi_r  <= '0;
      lo_r  <= '0;
    end else begin
      state <= state_nxt;
      if (accept) count <= '0;
      else if (state == MUL || state == DIV) count <= count + CNT_W'(1);
      if (accept && op_e == 3'd4) hi_r <= src_a_e;
      if (accept && op_e == 3'd5) lo_r <= src_a_e;
      if (state == FIXUP) begin
        hi_r <= fix_hi;
        lo_r <= fix_lo;
      end
    end
  end

  // Datapath registers: operand latch on accept, then one bit per cycle.
  always_ff @(posedge clk) begin
    if (accept && (op_mul || op_div)) begin
      mcand    <= {{WIDTH{1'b0}}, cond_neg(src_a_e, sgn_a)};
      mplier   <= cond_neg(src_b_e, sgn_b);
      prod     <= op_div ? {{WIDTH{1'b0}}, cond_neg(src_a_e, sgn_a)} : '0;
      is_div   <= op_div;
      neg_res  <= sgn_a ^ sgn_b;
      neg_rem  <= sgn_a;
      div_zero <= (src_b_e == '0);
    end else if (state == MUL) begin
      prod   <= mul_sum;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
    end else if (state == DIV) begin
      if (!div_diff[WIDTH])
        prod <= {div_diff[WIDTH-1:0], prod[WIDTH-2:0], 1'b1};
      else
        prod <= {div_shift[WIDTH-1:0], prod[WIDTH-2:0], 1'b0};
    end
  end

  assign busy = (state != IDLE);
  assign hi   = hi_r;
  assign lo   = lo_r;

endmodule

// File: tb/tb_execute_muldiv.sv
// Testbench for execute_muldiv. Expected HI/LO values and busy durations come
// from a behavioural model built on 64-bit arithmetic. They are pushed to a
// scoreboard queue when an operation is issued, then popped and compared when
// busy falls.
module tb_execute_muldiv;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_e;
  logic        sig_clr;
  logic [2:0]  op_e;
  logic [31:0] src_a_e;
  logic [31:0] src_b_e;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } exp_t;

  exp_t sb[$];

  execute_muldiv #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start_e(start_e), .sig_clr(sig_clr), .op_e(op_e),
    .src_a_e(src_a_e), .src_b_e(src_b_e), .busy(busy), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  // Behavioural reference for MULT/MULTU/DIV/DIVU.
  function automatic exp_t model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    logic signed [63:0] p, q, r;
    logic [63:0] pu;
    logic [31:0] m;
    int bl;
    e.hi = '0; e.lo = '0; e.cyc = 33;
    case (op)
      3'd0: begin
        p = 64'(signed'(a)) * 64'(signed'(b));
        e.hi = p[63:32]; e.lo = p[31:0];
      end
      3'd1: begin
        pu = {32'b0, a} * {32'b0, b};
        e.hi = pu[63:32]; e.lo = pu[31:0];
      end
      3'd2: begin
        if (b == 0) begin
          e.hi = a; e.lo = '1;
        end else begin
          q = 64'(signed'(a)) / 64'(signed'(b));
          r = 64'(signed'(a)) % 64'(signed'(b));
          e.hi = r[31:0]; e.lo = q[31:0];
        end
      end
      default: begin
        if (b == 0) begin
          e.hi = a; e.lo = '1;
        end else begin
          e.hi = a % b; e.lo = a / b;
        end
      end
    endcase
`ifdef MULDIV_EARLY_OUT_EN
    if (op == 3'd0 || op == 3'd1) begin
      m = (op == 3'd0 && b[31]) ? (~b + 32'd1) : b;
      bl = 0;
      for (int i = 0; i < 32; i++) if (m[i]) bl = i + 1;
      e.cyc = ((bl < 1) ? 1 : bl) + 1;
    end
`else
    m = '0; bl = 0;
`endif
    return e;
  endfunction

  // Present one start pulse for an edge; returns at the following negedge.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    start_e = 1'b1; op_e = op; src_a_e = a; src_b_e = b;
    @(negedge clk);
    start_e = 1'b0;
  endtask

  // Count negedges on which busy is high, bounded.
  task automatic wait_done(output int cyc);
    cyc = 0;
    while (busy === 1'b1 && cyc < 200) begin
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b want=0", busy); end
    total++; if (hi !== 32'd0) begin bad++; $display("FAIL reset_hi got=%h want=00000000", hi); end
    total++; if (lo !== 32'd0) begin bad++; $display("FAIL reset_lo got=%h want=00000000", lo); end
  endtask

  task automatic test_mt;
    issue(3'd5, 32'h0000_5678, 32'h0);
    issue(3'd4, 32'h0000_1234, 32'h0);
    total++; if (hi !== 32'h1234) begin bad++; $display("FAIL mthi_hi got=%h want=00001234", hi); end
    total++; if (lo !== 32'h5678) begin bad++; $display("FAIL mthi_lo got=%h want=00005678", lo); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL mthi_busy got=%0b want=0", busy); end
    issue(3'd6, 32'hAAAA_AAAA, 32'h1);
    total++; if (busy !== 1'b0 || hi !== 32'h1234 || lo !== 32'h5678) begin
      bad++; $display("FAIL noop_op6 busy=%0b hi=%h lo=%h want 0/00001234/00005678", busy, hi, lo);
    end
  endtask

  task automatic test_sig_clr;
    sig_clr = 1'b1;
    issue(3'd4, 32'hDEAD_BEEF, 32'h0);
    total++; if (hi !== 32'h1234) begin bad++; $display("FAIL clr_mthi got=%h want=00001234", hi); end
    issue(3'd0, 32'd3, 32'd5);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL clr_mult_busy got=%0b want=0", busy); end
    sig_clr = 1'b0;
  endtask

  task automatic run_table(input string name, input logic [2:0] ops[], input logic [31:0] as[], input logic [31:0] bs[]);
    exp_t e;
    int cyc;
    foreach (ops[i]) begin
      sb.push_back(model(ops[i], as[i], bs[i]));
      issue(ops[i], as[i], bs[i]);
      wait_done(cyc);
      e = sb.pop_front();
      total++; if (hi !== e.hi) begin bad++; $display("FAIL %s[%0d]_hi got=%h want=%h", name, i, hi, e.hi); end
      total++; if (lo !== e.lo) begin bad++; $display("FAIL %s[%0d]_lo got=%h want=%h", name, i, lo, e.lo); end
      total++; if (cyc != e.cyc) begin bad++; $display("FAIL %s[%0d]_busy_cycles got=%0d want=%0d", name, i, cyc, e.cyc); end
    end
  endtask

  task automatic test_mul;
    logic [2:0]  ops[] = '{3'd1, 3'd0, 3'd1, 3'd0, 3'd0, 3'd1, 3'd0, 3'd1, 3'd0, 3'd1};
    logic [31:0] as[]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'd9, 32'h8000_0000, 32'd12345,
                           32'd0, 32'hFFFF_FFFF, 32'd77, 32'h0, 32'h0};
    logic [31:0] bs[]  = '{32'hFFFF_FFFF, 32'd7, 32'd3, 32'h8000_0000, 32'hFFFF_FD4A,
                           32'd5, 32'd1, 32'd0, 32'h0, 32'h0};
    as[8] = $urandom; bs[8] = $urandom;
    as[9] = $urandom; bs[9] = $urandom_range(1, 255);
    run_table("mul", ops, as, bs);
  endtask

  task automatic test_div;
    logic [2:0]  ops[] = '{3'd2, 3'd2, 3'd3, 3'd2, 3'd3, 3'd2, 3'd2, 3'd3, 3'd2, 3'd3};
    logic [31:0] as[]  = '{32'hFFFF_FFF9, 32'h8000_0000, 32'd5, 32'hFFFF_FFFB, 32'd100,
                           32'd7, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 32'h0, 32'h0};
    logic [31:0] bs[]  = '{32'd2, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'd7,
                           32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'd1, 32'h0, 32'h0};
    as[8] = $urandom; bs[8] = $urandom_range(1, 32'h7FFF_FFFF) | 32'h8000_0000;
    as[9] = $urandom; bs[9] = $urandom_range(1, 1000);
    run_table("div", ops, as, bs);
  endtask

  task automatic test_reset_mid;
    issue(3'd4, 32'h1111_1111, 32'h0);
    issue(3'd5, 32'h2222_2222, 32'h0);
    issue(3'd0, 32'hFFFF_FFFD, 32'd7);
    repeat (9) @(negedge clk);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL midrst_busy_before got=%0b want=1", busy); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++; if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      bad++; $display("FAIL midrst busy=%0b hi=%h lo=%h want 0/00000000/00000000", busy, hi, lo);
    end
  endtask

  task automatic test_back_to_back;
    exp_t e;
    int cyc;
    issue(3'd4, 32'h0000_4444, 32'h0);
    sb.push_back(model(3'd1, 32'h1234_5678, 32'h8000_0001));
    issue(3'd1, 32'h1234_5678, 32'h8000_0001);
    // Hammer start_e (and a flush) while the multiply is in flight.
    start_e = 1'b1; op_e = 3'd4; src_a_e = 32'hDEAD_BEEF; src_b_e = 32'h0;
    @(negedge clk);
    total++; if (hi !== 32'h0000_4444) begin bad++; $display("FAIL busy_mthi_hold got=%h want=00004444", hi); end
    op_e = 3'd2; src_a_e = 32'd100; src_b_e = 32'd3; sig_clr = 1'b1;
    @(negedge clk);
    op_e = 3'd0; src_a_e = 32'd2; src_b_e = 32'd2; sig_clr = 1'b0;
    @(negedge clk);
    start_e = 1'b0;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL busy_after_clr got=%0b want=1", busy); end
    wait_done(cyc);
    e = sb.pop_front();
    total++; if (hi !== e.hi) begin bad++; $display("FAIL b2b_first_hi got=%h want=%h", hi, e.hi); end
    total++; if (lo !== e.lo) begin bad++; $display("FAIL b2b_first_lo got=%h want=%h", lo, e.lo); end
    total++; if (cyc + 3 != e.cyc) begin bad++; $display("FAIL b2b_first_cycles got=%0d want=%0d", cyc + 3, e.cyc); end
    // Immediately follow with another op on the first idle cycle.
    sb.push_back(model(3'd2, 32'hFFFF_FF9C, 32'd7));
    issue(3'd2, 32'hFFFF_FF9C, 32'd7);
    wait_done(cyc);
    e = sb.pop_front();
    total++; if (hi !== e.hi || lo !== e.lo) begin
      bad++; $display("FAIL b2b_second got hi=%h lo=%h want hi=%h lo=%h", hi, lo, e.hi, e.lo);
    end
    total++; if (cyc != e.cyc) begin bad++; $display("FAIL b2b_second_cycles got=%0d want=%0d", cyc, e.cyc); end
  endtask

  initial begin
    rst = 1'b1; start_e = 1'b0; sig_clr = 1'b0; op_e = 3'd0; src_a_e = '0; src_b_e = '0;
    @(negedge clk);
    test_reset;
    test_mt;
    test_sig_clr;
    test_mul;
    test_div;
    test_reset_mid;
    test_back_to_back;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
